id_stage_mt: RTL
================

// Module: id_stage_mt
// PURPOSE
//  Parametrised decode stage for the multithreaded RV32I pipeline, sitting between fetch and EX.
//  Holds one GPR bank per hart and decodes one instruction per cycle.
//  Resolves branch/jump targets in ID and drives an ID/EX register with a valid/ready handshake.
//  Supports per-hart flush and an optional load-use scoreboard.
// PARAMETERS
//  NHARTS   4   hardware threads, >=2; HW = $clog2(NHARTS)
//  XLEN     32  datapath width (32 or 64); instr stays 32 bits
// PORTS
//  clk            in   1       clock, all state on posedge
//  reset          in   1       synchronous, active-high
//  in_valid       in   1       fetch presents an instruction
//  in_ready       out  1       ID accepts this cycle
//  in_instr       in   32      instruction word
//  in_pc          in   XLEN    PC of in_instr
//  in_hart        in   HW      hart owning in_instr
//  wb_we          in   1       writeback enable
//  wb_hart        in   HW      writeback hart
//  wb_addr        in   5       writeback rd
//  wb_data        in   XLEN    writeback data
//  fwd_sel_rs1    in   2       0 = regfile, 2 = mem data, 3 = ex data, 1 = regfile (reserved)
//  fwd_sel_rs2    in   2       same encoding for rs2
//  fwd_mem_data   in   XLEN    forwarded MEM result
//  fwd_ex_data    in   XLEN    forwarded EX result
//  flush_mask     in   NHARTS  bit h kills hart h in ID and ID/EX
//  br_taken       out  1       conditional branch taken (comb, gated by in_valid)
//  jump           out  1       JAL/JALR in ID (comb, gated by in_valid)
//  br_target      out  XLEN    in_pc + imm
//  jmp_target     out  XLEN    JALR: (rs1 + imm) & ~1; JAL: in_pc + imm
//  ex_ready       in   1       EX accepts the ID/EX entry
//  ex_valid       out  1       ID/EX entry valid
//  ex_hart        out  HW      hart of the entry
//  ex_ctrl        out  ctrl_t  decoded control (id_pkg)
//  ex_rs1         out  XLEN    forwarded rs1
//  ex_rs2         out  XLEN    forwarded rs2
//  ex_imm         out  XLEN    sign-extended immediate
//  ex_pc          out  XLEN    PC
//  ex_instr       out  32      raw instruction
// BEHAVIOUR
//  Reset: ex_valid = 0; ex_* = 0; ctrl_t = '0 (NOP); all GPRs = 0; scoreboard cleared.
//  Handshake:
//   - in_ready = (!ex_valid | ex_ready) & !hazard.
//   - Transfer when in_valid & in_ready; latency 1 cycle into ID/EX.
//   - ID/EX holds all fields stable while ex_valid & !ex_ready.
//  Flush (priority over load):
//   - ex_valid & flush_mask[ex_hart] -> ex_valid = 0 next cycle.
//   - in_valid & flush_mask[in_hart] -> in_ready = 1, instruction discarded, not loaded.
//   - Other harts are unaffected.
//  GPRs:
//   - x0 reads 0; writes to x0 ignored.
//   - Read of the same hart/addr being written this cycle returns wb_data (write-through).
//  Forwarding: fwd_sel mux feeds branch compare, JALR base, ex_rs1 and ex_rs2.
//  Arithmetic:
//   - imm sign-extended from bit 31 to XLEN.
//   - Targets computed modulo 2^XLEN (wrap, no overflow flag).
//  Illegal opcode: ctrl_t.illegal = 1, RegWrite/MemWrite/MemRead forced 0.
// CONFIGURATION
//  `ID_SCOREBOARD_EN defined:
//   - Per-hart 32-bit pending mask.
//   - Set on transfer of a load with rd != 0.
//   - Cleared by wb_we on (wb_hart, wb_addr).
//   - Cleared when a load in ID/EX is flushed.
//   - hazard = used rs1/rs2 of in_hart pending and not cleared this cycle.
//   - Set and clear of the same bit in one cycle: set wins.
//  Not defined: hazard = 0; load-use handling relies solely on fwd_sel and external stall.
// STRUCTURE
//  id_pkg:
//   - opcode localparams, alu_op_e, imm_sel_e, ctrl_t packed struct;
//   - decode_f() and imm_f() functions.
//  Sub-module id_regbank (NHARTS x 31 x XLEN, 2R1W, write-through).
//  Top holds forwarding, branch compare, ID/EX register and scoreboard.
// TESTING
//  1. reset high 2 cycles -> ex_valid = 0, ex_ctrl = NOP; read x5 of any hart returns 0.
//  2. wb hart2 x7 = 0xA5A5A5A5; same cycle ADD x1,x7,x0 hart2 -> ex_rs1 = 0xA5A5A5A5.
//     Same ADD on hart1 -> ex_rs1 = 0.
//  3. ex_ready = 0 for 3 cycles with ex_valid -> in_ready = 0, ex_* stable.
//     ex_ready = 1 -> next instruction loads the following cycle.
//  4. BEQ hart0 pc = 0x100, imm = -8, rs1 = rs2 = 5 -> br_taken = 1, br_target = 0xF8.
//     fwd_sel_rs1 = 3, fwd_ex_data = 6 -> br_taken = 0.
//  5. ex_valid hart3, flush_mask = 4'b1000, in_valid hart1 -> ex_valid hart1 next cycle.
//     in_valid hart3 with flush_mask[3] -> dropped.
//  6. SCOREBOARD_EN: LW x4 hart0, then ADD x5,x4,x4 hart0 -> in_ready = 0 until wb x4 hart0.
//     ADD on hart1 proceeds.

Source files
------------

// File: rtl/id_pkg.sv
// ============================================================================
// id_pkg : RV32I decode types, opcodes and decode/immediate helper functions
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package id_pkg;

  localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
  localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
  localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
  localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
  localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] c_OPC_OP     = 7'b0110011;
  localparam logic [6:0] c_OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] c_OPC_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
  } imm_sel_e;

  typedef struct packed {
    logic       illegal;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       jalr;
    logic       alu_src;
    logic       use_rs1;
    logic       use_rs2;
    logic [2:0] funct3;
    alu_op_e    alu_op;
    imm_sel_e   imm_sel;
  } ctrl_t;

  localparam ctrl_t c_CTRL_NOP = '0;

  function automatic alu_op_e alu_f(input logic [2:0] f3, input logic b30, input logic is_imm);
    case (f3)
      3'b000:  alu_f = (b30 && !is_imm) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_f = ALU_SLL;
      3'b010:  alu_f = ALU_SLT;
      3'b011:  alu_f = ALU_SLTU;
      3'b100:  alu_f = ALU_XOR;
      3'b101:  alu_f = b30 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_f = ALU_OR;
      default: alu_f = ALU_AND;
    endcase
  endfunction

  // Unknown opcodes yield illegal with every side-effect flag left at zero.
  function automatic ctrl_t decode_f(input logic [31:0] instr);
    ctrl_t c;
    c        = c_CTRL_NOP;
    c.funct3 = instr[14:12];
    case (instr[6:0])
      c_OPC_LUI:    begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.alu_op = ALU_PASSB; c.imm_sel = IMM_U; end
      c_OPC_AUIPC:  begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.imm_sel = IMM_U; end
      c_OPC_JAL:    begin c.reg_write = 1'b1; c.jump = 1'b1; c.imm_sel = IMM_J; end
      c_OPC_JALR:   begin c.reg_write = 1'b1; c.jump = 1'b1; c.jalr = 1'b1; c.use_rs1 = 1'b1; c.imm_sel = IMM_I; end
      c_OPC_BRANCH: begin c.branch = 1'b1; c.use_rs1 = 1'b1; c.use_rs2 = 1'b1; c.alu_op = ALU_SUB; c.imm_sel = IMM_B; end
      c_OPC_LOAD:   begin c.reg_write = 1'b1; c.mem_read = 1'b1; c.alu_src = 1'b1; c.use_rs1 = 1'b1; c.imm_sel = IMM_I; end
      c_OPC_STORE:  begin c.mem_write = 1'b1; c.alu_src = 1'b1; c.use_rs1 = 1'b1; c.use_rs2 = 1'b1; c.imm_sel = IMM_S; end
      c_OPC_OPIMM:  begin
        c.reg_write = 1'b1; c.alu_src = 1'b1; c.use_rs1 = 1'b1; c.imm_sel = IMM_I;
        c.alu_op    = alu_f(instr[14:12], instr[30], 1'b1);
      end
      c_OPC_OP:     begin
        c.reg_write = 1'b1; c.use_rs1 = 1'b1; c.use_rs2 = 1'b1;
        c.alu_op    = alu_f(instr[14:12], instr[30], 1'b0);
      end
      c_OPC_FENCE, c_OPC_SYSTEM: c.funct3 = instr[14:12];
      default:      c.illegal = 1'b1;
    endcase
    return c;
  endfunction

  function automatic logic [31:0] imm_f(input logic [31:0] i, input imm_sel_e sel);
    case (sel)
      IMM_I:   imm_f = {{20{i[31]}}, i[31:20]};
      IMM_S:   imm_f = {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   imm_f = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_U:   imm_f = {i[31:12], 12'b0};
      IMM_J:   imm_f = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: imm_f = 32'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/id_regbank.sv
// ============================================================================
// id_regbank : per-hart GPR banks, 2 read / 1 write, write-through on reads
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module id_regbank #(
  parameter int NHARTS = 4,
  parameter int XLEN   = 32,
  parameter int HW     = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_we,
  input  logic [HW-1:0]   i_wr_hart,
  input  logic [4:0]      i_wr_addr,
  input  logic [XLEN-1:0] i_wr_data,
  input  logic [HW-1:0]   i_rd_hart,
  input  logic [4:0]      i_rs1_addr,
  input  logic [4:0]      i_rs2_addr,
  output logic [XLEN-1:0] o_rs1_data,
  output logic [XLEN-1:0] o_rs2_data
);

  logic [XLEN-1:0] r_mem [NHARTS][1:31];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int h = 0; h < NHARTS; h++)
        for (int r = 1; r < 32; r++)
          r_mem[h][r] <= '0;
    end else if (i_we && (i_wr_addr != 5'd0)) begin
      r_mem[i_wr_hart][i_wr_addr] <= i_wr_data;
    end
  end

  function automatic logic [XLEN-1:0] rd_f(input logic [4:0] addr);
    if (addr == 5'd0)
      rd_f = '0;
    else if (i_we && (i_wr_hart == i_rd_hart) && (i_wr_addr == addr))
      rd_f = i_wr_data;
    else
      rd_f = r_mem[i_rd_hart][addr];
  endfunction

  assign o_rs1_data = rd_f(i_rs1_addr);
  assign o_rs2_data = rd_f(i_rs2_addr);

endmodule

`default_nettype wire

// File: rtl/id_stage_mt.sv
// ============================================================================
// id_stage_mt : multithreaded RV32I decode stage with ID/EX register.
// Optional load-use scoreboard enabled by `ID_SCOREBOARD_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module id_stage_mt
  import id_pkg::*;
#(
  parameter  int NHARTS = 4,
  parameter  int XLEN   = 32,
  localparam int HW     = $clog2(NHARTS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [HW-1:0]     in_hart,
  input  logic              wb_we,
  input  logic [HW-1:0]     wb_hart,
  input  logic [4:0]        wb_addr,
  input  logic [XLEN-1:0]   wb_data,
  input  logic [1:0]        fwd_sel_rs1,
  input  logic [1:0]        fwd_sel_rs2,
  input  logic [XLEN-1:0]   fwd_mem_data,
  input  logic [XLEN-1:0]   fwd_ex_data,
  input  logic [NHARTS-1:0] flush_mask,
  output logic              br_taken,
  output logic              jump,
  output logic [XLEN-1:0]   br_target,
  output logic [XLEN-1:0]   jmp_target,
  input  logic              ex_ready,
  output logic              ex_valid,
  output logic [HW-1:0]     ex_hart,
  output ctrl_t             ex_ctrl,
  output logic [XLEN-1:0]   ex_rs1,
  output logic [XLEN-1:0]   ex_rs2,
  output logic [XLEN-1:0]   ex_imm,
  output logic [XLEN-1:0]   ex_pc,
  output logic [31:0]       ex_instr
);

  ctrl_t           w_ctrl;
  logic [XLEN-1:0] w_imm, w_rf1, w_rf2, w_op1, w_op2, w_jalr_sum;
  logic            w_cond, w_hazard, w_in_flush, w_ex_flush, w_xfer;

  logic            r_ex_valid;
  logic [HW-1:0]   r_ex_hart;
  ctrl_t           r_ex_ctrl;
  logic [XLEN-1:0] r_ex_rs1, r_ex_rs2, r_ex_imm, r_ex_pc;
  logic [31:0]     r_ex_instr;

  assign w_ctrl = decode_f(in_instr);
  assign w_imm  = XLEN'($signed(imm_f(in_instr, w_ctrl.imm_sel)));

  id_regbank #(.NHARTS(NHARTS), .XLEN(XLEN), .HW(HW)) u_regbank (
    .clk        (clk),
    .rst        (reset),
    .i_we       (wb_we),
    .i_wr_hart  (wb_hart),
    .i_wr_addr  (wb_addr),
    .i_wr_data  (wb_data),
    .i_rd_hart  (in_hart),
    .i_rs1_addr (in_instr[19:15]),
    .i_rs2_addr (in_instr[24:20]),
    .o_rs1_data (w_rf1),
    .o_rs2_data (w_rf2)
  );

  // Select 1 is reserved and behaves like the register file.
  assign w_op1 = (fwd_sel_rs1 == 2'd2) ? fwd_mem_data :
                 (fwd_sel_rs1 == 2'd3) ? fwd_ex_data  : w_rf1;
  assign w_op2 = (fwd_sel_rs2 == 2'd2) ? fwd_mem_data :
                 (fwd_sel_rs2 == 2'd3) ? fwd_ex_data  : w_rf2;

  always_comb begin
    w_cond = 1'b0;
    case (w_ctrl.funct3)
      3'b000:  w_cond = (w_op1 == w_op2);
      3'b001:  w_cond = (w_op1 != w_op2);
      3'b100:  w_cond = ($signed(w_op1) <  $signed(w_op2));
      3'b101:  w_cond = ($signed(w_op1) >= $signed(w_op2));
      3'b110:  w_cond = (w_op1 <  w_op2);
      3'b111:  w_cond = (w_op1 >= w_op2);
      default: w_cond = 1'b0;
    endcase
  end

  assign br_taken   = in_valid & w_ctrl.branch & w_cond;
  assign jump       = in_valid & w_ctrl.jump;
  assign br_target  = in_pc + w_imm;
  assign w_jalr_sum = w_op1 + w_imm;
  assign jmp_target = w_ctrl.jalr ? {w_jalr_sum[XLEN-1:1], 1'b0} : br_target;

  assign w_in_flush = in_valid & flush_mask[in_hart];
  assign w_ex_flush = r_ex_valid & flush_mask[r_ex_hart];
  assign in_ready   = w_in_flush | ((~r_ex_valid | ex_ready) & ~w_hazard);
  assign w_xfer     = in_valid & in_ready & ~w_in_flush;

`ifdef ID_SCOREBOARD_EN
  logic [31:0] r_pend     [NHARTS];
  logic [31:0] w_pend_nxt [NHARTS];
  logic [31:0] w_pend_in;

  // A writeback landing this cycle already resolves the dependency.
  always_comb begin
    w_pend_in = r_pend[in_hart];
    if (wb_we && (wb_hart == in_hart))
      w_pend_in[wb_addr] = 1'b0;
    w_hazard = in_valid & ~w_in_flush &
               ((w_ctrl.use_rs1 & w_pend_in[in_instr[19:15]]) |
                (w_ctrl.use_rs2 & w_pend_in[in_instr[24:20]]));
  end

  always_comb begin
    for (int h = 0; h < NHARTS; h++) begin
      w_pend_nxt[h] = r_pend[h];
      if (wb_we && (wb_hart == HW'(h)))
        w_pend_nxt[h][wb_addr] = 1'b0;
      if (w_ex_flush && r_ex_ctrl.mem_read && (r_ex_hart == HW'(h)))
        w_pend_nxt[h][r_ex_instr[11:7]] = 1'b0;
      if (w_xfer && w_ctrl.mem_read && (in_hart == HW'(h)) && (in_instr[11:7] != 5'd0))
        w_pend_nxt[h][in_instr[11:7]] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int h = 0; h < NHARTS; h++)
      r_pend[h] <= reset ? 32'b0 : w_pend_nxt[h];
  end
`else
  assign w_hazard = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex_valid <= 1'b0;
      r_ex_hart  <= '0;
      r_ex_ctrl  <= c_CTRL_NOP;
      r_ex_rs1   <= '0;
      r_ex_rs2   <= '0;
      r_ex_imm   <= '0;
      r_ex_pc    <= '0;
      r_ex_instr <= '0;
    end else if (w_xfer) begin
      r_ex_valid <= 1'b1;
      r_ex_hart  <= in_hart;
      r_ex_ctrl  <= w_ctrl;
      r_ex_rs1   <= w_op1;
      r_ex_rs2   <= w_op2;
      r_ex_imm   <= w_imm;
      r_ex_pc    <= in_pc;
      r_ex_instr <= in_instr;
    end else if (w_ex_flush || ex_ready) begin
      r_ex_valid <= 1'b0;
    end
  end

  assign ex_valid = r_ex_valid;
  assign ex_hart  = r_ex_hart;
  assign ex_ctrl  = r_ex_ctrl;
  assign ex_rs1   = r_ex_rs1;
  assign ex_rs2   = r_ex_rs2;
  assign ex_imm   = r_ex_imm;
  assign ex_pc    = r_ex_pc;
  assign ex_instr = r_ex_instr;

endmodule

`default_nettype wire
